// File: rtl/cpc_ramcfg_capture.sv
// Snoops Z80 I/O writes to the CPC RAM-config port and hands {ccc,bbb} to the bank mapper.
// Define FULL_DECODE_EN to require adr_hi == 7'h7F in addition to adr15 == 0.
module cpc_ramcfg_capture #(
  parameter int QUAL_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iorq_b,
  input  logic             wr_b,
  input  logic             m1_b,
  input  logic             adr15,
  input  logic [6:0]       adr_hi,
  input  logic [7:0]       data,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [5:0]       cfg_data,
  output logic             overrun,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    WAIT_END
  } state_t;

  localparam logic [2:0]       QUAL_N  = 3'(QUAL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       iorq_s1, iorq_s2;
  logic       wr_s1, wr_s2;
  logic       m1_s1, m1_s2;
  logic       adr15_r;
  logic [7:0] data_r;
  logic       port_sel;
  logic       hit;

  state_t     state;
  logic [2:0] qual_cnt;
  logic [2:0] qual_next;
  logic       cap_pulse;
  logic [5:0] cap_word;

  // Strobes resynchronised through two flops; address/data only need one stage
  // because they are stable well before the strobes fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      iorq_s1 <= 1'b1;
      iorq_s2 <= 1'b1;
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      m1_s1   <= 1'b1;
      m1_s2   <= 1'b1;
      adr15_r <= 1'b1;
      data_r  <= 8'h00;
    end else begin
      iorq_s1 <= iorq_b;
      iorq_s2 <= iorq_s1;
      wr_s1   <= wr_b;
      wr_s2   <= wr_s1;
      m1_s1   <= m1_b;
      m1_s2   <= m1_s1;
      adr15_r <= adr15;
      data_r  <= data;
    end
  end

`ifdef FULL_DECODE_EN
  logic [6:0] adr_hi_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      adr_hi_r <= 7'h00;
    end else begin
      adr_hi_r <= adr_hi;
    end
  end

  assign port_sel = ~adr15_r & (adr_hi_r == 7'h7F);
`else
  logic unused_adr_hi;

  assign unused_adr_hi = ^adr_hi;
  assign port_sel      = ~adr15_r;
`endif

  assign hit       = ~iorq_s2 & ~wr_s2 & m1_s2 & port_sel & (data_r[7:6] == 2'b11);
  assign qual_next = qual_cnt + 3'd1;

  // Qualification FSM: hit must persist QUAL_CYCLES samples, then one capture
  // per bus cycle no matter how long the strobes stay low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      qual_cnt  <= 3'd0;
      cap_pulse <= 1'b0;
      cap_word  <= 6'b000000;
    end else begin
      cap_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            qual_cnt <= 3'd1;
            if (QUAL_N == 3'd1) begin
              cap_pulse <= 1'b1;
              cap_word  <= data_r[5:0];
              state     <= WAIT_END;
            end else begin
              state <= QUAL;
            end
          end
        end
        QUAL: begin
          if (!hit) begin
            state <= IDLE;
          end else if (qual_next == QUAL_N) begin
            qual_cnt  <= qual_next;
            cap_pulse <= 1'b1;
            cap_word  <= data_r[5:0];
            state     <= WAIT_END;
          end else begin
            qual_cnt <= qual_next;
          end
        end
        WAIT_END: begin
          if (iorq_s2 && wr_s2) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep output buffer: newest word always wins, overwriting an unaccepted
  // word raises the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_valid <= 1'b0;
      cfg_data  <= 6'b000000;
      overrun   <= 1'b0;
      wr_count  <= '0;
    end else begin
      if (cap_pulse) begin
        cfg_valid <= 1'b1;
        cfg_data  <= cap_word;
        if (cfg_valid && !cfg_ready) begin
          overrun <= 1'b1;
        end
        if (wr_count != CNT_MAX) begin
          wr_count <= wr_count + CNT_W'(1);
        end
      end else if (cfg_valid && cfg_ready) begin
        cfg_valid <= 1'b0;
      end
    end
  end

endmodule
